// File: rtl/app_mode_controller.sv
// app_mode_controller: button front-end, application select and timer alarm sequencer.
// Latency: raw button rise sampled at edge N gives an output pulse during cycle N+3.
//   A mode pulse moves sel one cycle after the pulse.
// Backpressure: none. Pulses are fire-and-forget, and in ALERT the first pulse is consumed.
// Optional feature macro: AUTO_SWITCH_EN. When it is defined, a timer finishing while another
//   app is selected switches to the timer app and rings straight away, with no ALERT blink.
module app_mode_controller #(
  parameter int NUM_APPS  = 3,   // selectable apps, legal 2..4
  parameter int TIMER_SEL = 2,   // sel code of the countdown timer app
  parameter int BLINK_DIV = 50   // cycles per alarm half-period while in ALERT (min 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic       btn_dec_i,
  input  logic       btn_state_i,
  input  logic       btn_start_i,
  input  logic       timer_done_i,
  output logic [1:0] sel_o,
  output logic       inc_o,
  output logic       dec_o,
  output logic       state_o,
  output logic       start_o,
  output logic       alarm_o
);

  // Bit positions of the buttons inside the packed button vectors.
  localparam int BTN_MODE  = 4;
  localparam int BTN_INC   = 3;
  localparam int BTN_DEC   = 2;
  localparam int BTN_STATE = 1;
  localparam int BTN_START = 0;

  localparam logic [1:0] SEL_LAST  = 2'(NUM_APPS - 1);
  localparam logic [1:0] SEL_TIMER = 2'(TIMER_SEL);

  localparam int              CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_ALERT   = 2'd1,
    ST_RINGING = 2'd2
  } state_t;

  logic [4:0] btn_raw;
  logic [4:0] sync1_q;
  logic [4:0] sync2_q;
  logic [4:0] prev_q;
  logic [4:0] pulse_q;
  logic       done_q;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;

  logic       mode_p;
  logic       any_p;
  logic       done_rise;
  logic [1:0] sel_step;
  logic       fwd_en;
  logic       alarm_d;

  assign btn_raw = {btn_mode_i, btn_inc_i, btn_dec_i, btn_state_i, btn_start_i};

  // Two-flop synchroniser followed by a registered rising-edge detector for every button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  // Delayed copy of timer_done, used to find its rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= timer_done_i;
    end
  end

  assign mode_p    = pulse_q[BTN_MODE];
  assign any_p     = |pulse_q;
  assign done_rise = timer_done_i & ~done_q;
  assign sel_step  = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;

  // FSM, select and blink state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_NORMAL;
      sel_q       <= 2'd0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  // Next state, select update, blink timing and the pulse-forwarding gate.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;
    fwd_en      = 1'b1;
    alarm_d     = 1'b0;

    case (state_q)
      ST_NORMAL: begin
        if (mode_p) begin
          sel_d = sel_step;
        end
        // The alarm decision looks at the select value from before any mode step in this cycle.
        if (done_rise) begin
          if (sel_q == SEL_TIMER) begin
            state_d = ST_RINGING;
          end else begin
`ifdef AUTO_SWITCH_EN
            sel_d   = SEL_TIMER;
            state_d = ST_RINGING;
`else
            state_d = ST_ALERT;
`endif
          end
        end
      end

      ST_ALERT: begin
        // Buttons are swallowed here: the first press only acknowledges the alarm.
        fwd_en  = 1'b0;
        alarm_d = ~blink_ph_q;
        if (blink_cnt_q == CNT_LAST) begin
          blink_cnt_d = '0;
          blink_ph_d  = ~blink_ph_q;
        end else begin
          blink_cnt_d = blink_cnt_q + CNT_W'(1);
          blink_ph_d  = blink_ph_q;
        end
        if (!timer_done_i) begin
          state_d     = ST_NORMAL;
          blink_cnt_d = '0;
          blink_ph_d  = 1'b0;
        end else if (any_p) begin
          sel_d       = SEL_TIMER;
          state_d     = ST_RINGING;
          blink_cnt_d = '0;
          blink_ph_d  = 1'b0;
        end
      end

      ST_RINGING: begin
        alarm_d = 1'b1;
        if (mode_p) begin
          sel_d = sel_step;
        end
        if (!timer_done_i) begin
          state_d = ST_NORMAL;
        end else if (mode_p && (sel_q == SEL_TIMER) && (sel_step != SEL_TIMER)) begin
`ifdef AUTO_SWITCH_EN
          state_d = ST_RINGING;
`else
          // User walked away from the still-ringing timer: nag with the blinking alarm.
          state_d = ST_ALERT;
`endif
        end
      end

      default: begin
        state_d = ST_NORMAL;
      end
    endcase
  end

  // Mode has priority: any other pulse landing in the same cycle as a mode pulse is dropped.
  always_comb begin
    inc_o   = fwd_en & ~mode_p & pulse_q[BTN_INC];
    dec_o   = fwd_en & ~mode_p & pulse_q[BTN_DEC];
    state_o = fwd_en & ~mode_p & pulse_q[BTN_STATE];
    start_o = fwd_en & ~mode_p & pulse_q[BTN_START];
  end

  assign sel_o   = sel_q;
  assign alarm_o = alarm_d;

endmodule
